// File: rtl/accelerator_tensor_stream_pkg.sv
// Shared types for the tensor element-stream source.
// FSM encoding and single-bit constants used by the top.
package accelerator_tensor_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        LAUNCH,
        SEND,
        WAIT_REQ,
        DRAIN
    } state_e;

    localparam logic ZERO = 1'b0;
    localparam logic ONE  = 1'b1;

endpackage

// File: rtl/accelerator_tensor_buffer.sv
// Element buffer for the stream source.
// One write port, one read port, registered read data.
module accelerator_tensor_buffer #(
    parameter int DATA_SIZE = 64,
    parameter int ADDR_SIZE = 6
) (
    input  logic                 clk_i,
    input  logic                 wr_en_i,
    input  logic [ADDR_SIZE-1:0] wr_addr_i,
    input  logic [DATA_SIZE-1:0] wr_data_i,
    input  logic [ADDR_SIZE-1:0] rd_addr_i,
    output logic [DATA_SIZE-1:0] rd_data_o
);

    logic [DATA_SIZE-1:0] mem_q [2**ADDR_SIZE];
    logic [DATA_SIZE-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/accelerator_tensor_stream_source.sv
// Transmit side of the tensor element-stream protocol.
// Streams a buffered I x J x K tensor, one element per consumer request.
module accelerator_tensor_stream_source
    import accelerator_tensor_stream_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4,
    parameter int ADDR_SIZE    = 6
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    output logic                 ERROR,
    input  logic                 WRITE_ENABLE,
    input  logic [ADDR_SIZE-1:0] WRITE_ADDRESS,
    input  logic [DATA_SIZE-1:0] WRITE_DATA,
    input  logic [DATA_SIZE-1:0] SIZE_I_IN,
    input  logic [DATA_SIZE-1:0] SIZE_J_IN,
    input  logic [DATA_SIZE-1:0] SIZE_K_IN,
    output logic                 TX_START,
    output logic [DATA_SIZE-1:0] TX_SIZE_I,
    output logic [DATA_SIZE-1:0] TX_SIZE_J,
    output logic [DATA_SIZE-1:0] TX_SIZE_K,
    output logic                 TX_DATA_ENABLE,
    output logic [DATA_SIZE-1:0] TX_DATA,
    output logic                 TX_LAST,
    input  logic                 TX_REQUEST,
    input  logic                 TX_READY
);

    localparam int TotW = 3 * DATA_SIZE;
    localparam int CntW = ADDR_SIZE + 1;
    localparam logic [TotW-1:0] DEPTH = TotW'(1) << ADDR_SIZE;

    if (CONTROL_SIZE < 1) begin : g_bad_control_size
        $error("CONTROL_SIZE must be positive");
    end

    state_e               state_q, state_d;
    logic [CntW-1:0]      n_q, n_d;
    logic [CntW-1:0]      total_q, total_d;
    logic                 pend_q, pend_d;
    logic                 ready_q, ready_d;
    logic                 error_q, error_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic [DATA_SIZE-1:0] si_q, si_d;
    logic [DATA_SIZE-1:0] sj_q, sj_d;
    logic [DATA_SIZE-1:0] sk_q, sk_d;

    logic [TotW-1:0]      total;
    logic                 is_last;
    logic                 sending;
    logic [DATA_SIZE-1:0] rd_data;

    // Full-width product so huge dimensions cannot alias into range.
    assign total   = TotW'(si_q) * TotW'(sj_q) * TotW'(sk_q);
    assign is_last = (n_q == total_q - CntW'(1));
    assign sending = (state_q == SEND);

    accelerator_tensor_buffer #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_buffer (
        .clk_i     (CLK),
        .wr_en_i   (WRITE_ENABLE && (state_q == IDLE)),
        .wr_addr_i (WRITE_ADDRESS),
        .wr_data_i (WRITE_DATA),
        .rd_addr_i (n_d[ADDR_SIZE-1:0]),
        .rd_data_o (rd_data)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        total_d = total_q;
        pend_d  = pend_q;
        ready_d = ZERO;
        error_d = ZERO;
        data_d  = data_q;
        si_d    = si_q;
        sj_d    = sj_q;
        sk_d    = sk_q;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    si_d    = SIZE_I_IN;
                    sj_d    = SIZE_J_IN;
                    sk_d    = SIZE_K_IN;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (total == '0) begin
                    ready_d = ONE;
                    state_d = IDLE;
                end else if (total > DEPTH) begin
                    ready_d = ONE;
                    error_d = ONE;
                    state_d = IDLE;
                end else begin
                    total_d = total[CntW-1:0];
                    n_d     = '0;
                    pend_d  = ZERO;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = SEND;
            end
            SEND: begin
                // Advancing n here issues the prefetch of the next element.
                data_d = rd_data;
                n_d    = n_q + CntW'(1);
                if (is_last) begin
                    state_d = DRAIN;
                end else begin
                    state_d = WAIT_REQ;
                    if (TX_REQUEST) begin
                        pend_d = ONE;
                    end
                end
            end
            WAIT_REQ: begin
                if (TX_REQUEST || pend_q) begin
                    pend_d  = ZERO;
                    state_d = SEND;
                end
            end
            DRAIN: begin
                pend_d = ZERO;
                if (TX_READY) begin
                    ready_d = ONE;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            n_q     <= '0;
            total_q <= '0;
            pend_q  <= ZERO;
            ready_q <= ZERO;
            error_q <= ZERO;
            data_q  <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            sk_q    <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            total_q <= total_d;
            pend_q  <= pend_d;
            ready_q <= ready_d;
            error_q <= error_d;
            data_q  <= data_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            sk_q    <= sk_d;
        end
    end

    assign READY          = ready_q;
    assign ERROR          = error_q;
    assign TX_START       = (state_q == LAUNCH);
    assign TX_SIZE_I      = si_q;
    assign TX_SIZE_J      = sj_q;
    assign TX_SIZE_K      = sk_q;
    assign TX_DATA_ENABLE = sending;
    assign TX_DATA        = sending ? rd_data : data_q;
    assign TX_LAST        = sending && is_last;

endmodule

// File: tb/tb_accelerator_tensor_stream_source.sv
// Bench for the tensor stream source: random and directed transfers,
// expected elements queued at START and popped by an output monitor.
module tb_accelerator_tensor_stream_source;

    localparam int DW    = 64;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic          READY;
    logic          ERROR;
    logic          WRITE_ENABLE;
    logic [AW-1:0] WRITE_ADDRESS;
    logic [DW-1:0] WRITE_DATA;
    logic [DW-1:0] SIZE_I_IN, SIZE_J_IN, SIZE_K_IN;
    logic          TX_START;
    logic [DW-1:0] TX_SIZE_I, TX_SIZE_J, TX_SIZE_K;
    logic          TX_DATA_ENABLE;
    logic [DW-1:0] TX_DATA;
    logic          TX_LAST;
    logic          TX_REQUEST;
    logic          TX_READY;

    always #5 CLK = ~CLK;

    accelerator_tensor_stream_source #(
        .DATA_SIZE    (DW),
        .CONTROL_SIZE (4),
        .ADDR_SIZE    (AW)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .START          (START),
        .READY          (READY),
        .ERROR          (ERROR),
        .WRITE_ENABLE   (WRITE_ENABLE),
        .WRITE_ADDRESS  (WRITE_ADDRESS),
        .WRITE_DATA     (WRITE_DATA),
        .SIZE_I_IN      (SIZE_I_IN),
        .SIZE_J_IN      (SIZE_J_IN),
        .SIZE_K_IN      (SIZE_K_IN),
        .TX_START       (TX_START),
        .TX_SIZE_I      (TX_SIZE_I),
        .TX_SIZE_J      (TX_SIZE_J),
        .TX_SIZE_K      (TX_SIZE_K),
        .TX_DATA_ENABLE (TX_DATA_ENABLE),
        .TX_DATA        (TX_DATA),
        .TX_LAST        (TX_LAST),
        .TX_REQUEST     (TX_REQUEST),
        .TX_READY       (TX_READY)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } elem_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] mem_m [DEPTH];
    elem_t         exp_elem[$];
    logic          exp_rdy[$];
    elem_t         mon_e;
    logic          mon_r;

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic event_fail(input string name, input logic [DW-1:0] val);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected output event (value %0h)", name, val);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            if (TX_DATA_ENABLE) begin
                if (exp_elem.size() == 0) begin
                    event_fail("unexpected_enable", TX_DATA);
                end else begin
                    mon_e = exp_elem.pop_front();
                    check("tx_data", TX_DATA, mon_e.data);
                    check("tx_last", 64'(TX_LAST), 64'(mon_e.last));
                end
            end else if (TX_LAST) begin
                event_fail("last_without_enable", 64'(TX_LAST));
            end
            if (READY) begin
                if (exp_rdy.size() == 0) begin
                    event_fail("unexpected_ready", 64'(ERROR));
                end else begin
                    mon_r = exp_rdy.pop_front();
                    check("ready_error_flag", 64'(ERROR), 64'(mon_r));
                end
            end else if (ERROR) begin
                event_fail("error_without_ready", 64'(ERROR));
            end
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_ready"}, 64'(READY), 64'd0);
        check({tag, "_error"}, 64'(ERROR), 64'd0);
        check({tag, "_tx_start"}, 64'(TX_START), 64'd0);
        check({tag, "_size_i"}, TX_SIZE_I, 64'd0);
        check({tag, "_size_j"}, TX_SIZE_J, 64'd0);
        check({tag, "_size_k"}, TX_SIZE_K, 64'd0);
        check({tag, "_enable"}, 64'(TX_DATA_ENABLE), 64'd0);
        check({tag, "_data"}, TX_DATA, 64'd0);
        check({tag, "_last"}, 64'(TX_LAST), 64'd0);
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        WRITE_ENABLE  = 1'b1;
        WRITE_ADDRESS = AW'(a);
        WRITE_DATA    = d;
        tick;
        WRITE_ENABLE  = 1'b0;
        mem_m[a]      = d;
    endtask

    task automatic noise_on;
        WRITE_ENABLE  = 1'b1;
        WRITE_ADDRESS = AW'($urandom_range(0, DEPTH - 1));
        WRITE_DATA    = {$urandom, $urandom};
        START         = 1'b1;
        SIZE_I_IN     = 64'($urandom_range(1, 3));
        SIZE_J_IN     = 64'($urandom_range(1, 3));
        SIZE_K_IN     = 64'($urandom_range(1, 3));
    endtask

    task automatic noise_off;
        WRITE_ENABLE = 1'b0;
        START        = 1'b0;
    endtask

    // mode: -2 request held high, -1 request pulsed during the send
    // cycle, >=0 request after that many idle wait cycles.
    task automatic run_xfer(input logic [DW-1:0] si, input logic [DW-1:0] sj,
                            input logic [DW-1:0] sk, input int mode,
                            input bit noise, input bit wr_same,
                            input int abort_at);
        logic [3*DW-1:0] tot;
        logic [DW-1:0]   v;
        int              total;
        int              d;
        tot = {128'd0, si} * {128'd0, sj} * {128'd0, sk};
        if (wr_same) begin
            v             = {$urandom, $urandom};
            WRITE_ENABLE  = 1'b1;
            WRITE_ADDRESS = '0;
            WRITE_DATA    = v;
            mem_m[0]      = v;
        end
        START     = 1'b1;
        SIZE_I_IN = si;
        SIZE_J_IN = sj;
        SIZE_K_IN = sk;
        if (tot == 0 || tot > DEPTH) begin
            exp_rdy.push_back(tot != 0);
            tick;
            noise_off();
            tick;
            check("early_ready", 64'(READY), 64'd1);
            check("early_error", 64'(ERROR), 64'(tot != 0));
            check("early_no_tx_start", 64'(TX_START), 64'd0);
            tick;
            check("early_ready_pulse", 64'(READY), 64'd0);
            check("early_no_enable", 64'(TX_DATA_ENABLE), 64'd0);
            check("early_no_launch", 64'(TX_START), 64'd0);
            return;
        end
        total = int'(tot);
        for (int e = 0; e < total; e++) begin
            exp_elem.push_back('{mem_m[e], e == total - 1});
        end
        exp_rdy.push_back(1'b0);
        tick;
        noise_off();
        check("check_cycle_no_start", 64'(TX_START), 64'd0);
        tick;
        check("tx_start_c2", 64'(TX_START), 64'd1);
        check("tx_size_i", TX_SIZE_I, si);
        check("tx_size_j", TX_SIZE_J, sj);
        check("tx_size_k", TX_SIZE_K, sk);
        if (mode == -2) TX_REQUEST = 1'b1;
        tick;
        check("tx_start_pulse", 64'(TX_START), 64'd0);
        for (int e = 0; e < total; e++) begin
            check("enable_timing", 64'(TX_DATA_ENABLE), 64'd1);
            if (e + 1 == abort_at) begin
                TX_REQUEST = 1'b0;
                noise_off();
                RST = 1'b1;
                exp_elem.delete();
                exp_rdy.delete();
                tick;
                check_quiet("abort");
                RST = 1'b0;
                repeat (4) begin
                    tick;
                    check("abort_no_ready", 64'(READY), 64'd0);
                end
                return;
            end
            if (e == total - 1) break;
            if (mode == -2) begin
                tick;
                check("hold_gap", 64'(TX_DATA_ENABLE), 64'd0);
                tick;
            end else if (mode == -1) begin
                TX_REQUEST = 1'b1;
                tick;
                TX_REQUEST = 1'b0;
                check("pending_gap", 64'(TX_DATA_ENABLE), 64'd0);
                tick;
            end else begin
                tick;
                if (noise) noise_on();
                repeat (mode) begin
                    check("wait_no_enable", 64'(TX_DATA_ENABLE), 64'd0);
                    tick;
                end
                TX_REQUEST = 1'b1;
                tick;
                TX_REQUEST = 1'b0;
                noise_off();
            end
        end
        TX_REQUEST = 1'b0;
        tick;
        d = $urandom_range(0, 3);
        repeat (d) begin
            TX_REQUEST = 1'($urandom_range(0, 1));
            check("drain_no_ready", 64'(READY), 64'd0);
            tick;
        end
        TX_REQUEST = 1'b0;
        TX_READY   = 1'b1;
        tick;
        TX_READY   = 1'b0;
        check("done_ready", 64'(READY), 64'd1);
        check("done_error", 64'(ERROR), 64'd0);
        check("done_size_i", TX_SIZE_I, si);
        check("done_size_j", TX_SIZE_J, sj);
        check("done_size_k", TX_SIZE_K, sk);
        tick;
        check("done_ready_pulse", 64'(READY), 64'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mode;
        RST           = 1'b1;
        START         = 1'b0;
        WRITE_ENABLE  = 1'b0;
        WRITE_ADDRESS = '0;
        WRITE_DATA    = '0;
        SIZE_I_IN     = '0;
        SIZE_J_IN     = '0;
        SIZE_K_IN     = '0;
        TX_REQUEST    = 1'b0;
        TX_READY      = 1'b0;
        repeat (3) tick;
        check_quiet("reset");
        RST = 1'b0;
        tick;

        for (int a = 0; a < DEPTH; a++) begin
            wr(a, (a < 8) ? 64'(a + 1) : {$urandom, $urandom});
        end

        run_xfer(2, 2, 2, 0, 0, 0, -1);
        run_xfer(2, 2, 2, 3, 0, 0, -1);
        run_xfer(2, 2, 2, 7, 1, 0, -1);
        run_xfer(0, 4, 4, 0, 0, 0, -1);
        run_xfer(5, 5, 5, 0, 0, 0, -1);
        run_xfer(2, 2, 2, -1, 0, 0, -1);
        run_xfer(1, 1, 4, -2, 0, 0, -1);
        run_xfer(2, 2, 2, 0, 0, 0, 3);
        run_xfer(2, 2, 2, 0, 0, 0, -1);
        run_xfer(64'h1_0000_0000, 64'h1_0000_0000, 1, 0, 0, 0, -1);
        run_xfer(5, 13, 1, 0, 0, 0, -1);
        run_xfer(4, 4, 4, 1, 1, 0, -1);
        run_xfer(1, 1, 1, 0, 0, 1, -1);
        run_xfer(1, 2, 3, 2, 0, 1, -1);

        for (int r = 0; r < 10; r++) begin
            repeat (8) wr($urandom_range(0, DEPTH - 1), {$urandom, $urandom});
            mode = int'($urandom_range(0, 7)) - 2;
            run_xfer(64'($urandom_range(1, 4)), 64'($urandom_range(1, 4)),
                     64'($urandom_range(1, 4)), mode,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end

        repeat (3) tick;
        check("leftover_elements", 64'(exp_elem.size()), 64'd0);
        check("leftover_ready", 64'(exp_rdy.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
